// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame controller.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DHI,
      DLO,
      SUM,
      ISSUE
   } state_e;

   localparam logic [7:0] DEF_HEADER = 8'hAA;
   localparam int         FRAME_LEN  = 5;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timer: counts cycles spent waiting inside a frame and flags
// expiry when the count reaches TIMEOUT_CYCLES-1. Only built when
// UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_timeout #(
   parameter int TIMEOUT_CYCLES = 2400,
   parameter int CNT_W          = 12
) (
   input  logic clk,
   input  logic rst,
   input  logic run,      // controller is mid-frame (ADDR..SUM)
   input  logic clr,      // a byte was taken this cycle
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] timer_q, timer_d;

   assign expired = run && (timer_q == LAST);

   // Restart on every taken byte, outside a frame and on expiry; else count.
   always_comb begin
      timer_d = timer_q + 1'b1;
      if (!run || clr || expired)
         timer_d = '0;
   end

   // Timer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) timer_q <= '0;
      else     timer_q <= timer_d;
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command-frame controller. Collects 5-byte frames
// (header, addr, data_hi, data_lo, checksum) from rx_uart, validates the
// 8-bit additive checksum and presents a register write on a valid/ready
// port. Back-pressure is applied by dropping rx_enable_signal while a
// command waits for acceptance.
// Optional: define UART_CMD_TIMEOUT_EN to abort frames whose inter-byte
// gap reaches TIMEOUT_CYCLES.
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] HEADER         = DEF_HEADER,
   parameter int         TIMEOUT_CYCLES = 2400,
   parameter int         CNT_W          = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_done_signal,
   input  logic [7:0]  rx_data,
   output logic        rx_enable_signal,
   output logic        cfg_valid,
   input  logic        cfg_ready,
   output logic [7:0]  cfg_addr,
   output logic [15:0] cfg_data,
   output logic        frame_err,
   output logic [7:0]  err_count
);

   state_e      state_q, state_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  hi_q, hi_d;
   logic [7:0]  lo_q, lo_d;
   logic [7:0]  sum_q, sum_d;
   logic        rx_en_q, rx_en_d;
   logic        cfg_valid_q, cfg_valid_d;
   logic [7:0]  cfg_addr_q, cfg_addr_d;
   logic [15:0] cfg_data_q, cfg_data_d;
   logic        frame_err_q, frame_err_d;
   logic [7:0]  err_cnt_q, err_cnt_d;

   logic taken;
   logic tmo_hit;
   logic bump_err;

   // Bytes arriving while a command is pending are dropped.
   assign taken = rx_done_signal && (state_q != ISSUE);

`ifdef UART_CMD_TIMEOUT_EN
   logic tmo_run;
   assign tmo_run = (state_q == ADDR) || (state_q == DHI) ||
                    (state_q == DLO)  || (state_q == SUM);

   uart_cmd_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .run     (tmo_run),
      .clr     (taken),
      .expired (tmo_hit)
   );
`else
   // No timer: a partial frame waits indefinitely.
   assign tmo_hit = 1'b0;
`endif

   // Frame assembly, checksum check, command handshake and error counting.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      sum_d       = sum_q;
      cfg_valid_d = cfg_valid_q;
      cfg_addr_d  = cfg_addr_q;
      cfg_data_d  = cfg_data_q;
      frame_err_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      bump_err    = 1'b0;

      case (state_q)
         IDLE: begin
            if (taken && (rx_data == HEADER))
               state_d = ADDR;
         end
         ADDR: begin
            if (taken) begin
               addr_d  = rx_data;
               sum_d   = rx_data;
               state_d = DHI;
            end
         end
         DHI: begin
            if (taken) begin
               hi_d    = rx_data;
               sum_d   = sum_q + rx_data;
               state_d = DLO;
            end
         end
         DLO: begin
            if (taken) begin
               lo_d    = rx_data;
               sum_d   = sum_q + rx_data;
               state_d = SUM;
            end
         end
         SUM: begin
            if (taken) begin
               if (rx_data == sum_q) begin
                  cfg_valid_d = 1'b1;
                  cfg_addr_d  = addr_q;
                  cfg_data_d  = {hi_q, lo_q};
                  state_d     = ISSUE;
               end else begin
                  bump_err = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         ISSUE: begin
            if (cfg_valid_q && cfg_ready) begin
               cfg_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A byte landing on the expiry cycle wins over the timeout.
      if (tmo_hit && !taken) begin
         bump_err = 1'b1;
         state_d  = IDLE;
      end

      if (bump_err) begin
         frame_err_d = 1'b1;
         if (err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   // Receiver enabled whenever no command is pending.
   always_comb begin
      rx_en_d = (state_d != ISSUE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         sum_q       <= '0;
         rx_en_q     <= 1'b0;
         cfg_valid_q <= 1'b0;
         cfg_addr_q  <= '0;
         cfg_data_q  <= '0;
         frame_err_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         sum_q       <= sum_d;
         rx_en_q     <= rx_en_d;
         cfg_valid_q <= cfg_valid_d;
         cfg_addr_q  <= cfg_addr_d;
         cfg_data_q  <= cfg_data_d;
         frame_err_q <= frame_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign rx_enable_signal = rx_en_q;
   assign cfg_valid        = cfg_valid_q;
   assign cfg_addr         = cfg_addr_q;
   assign cfg_data         = cfg_data_q;
   assign frame_err        = frame_err_q;
   assign err_count        = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl.
module tb_uart_cmd_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_done_signal;
   logic [7:0]  rx_data;
   logic        rx_enable_signal;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [7:0]  cfg_addr;
   logic [15:0] cfg_data;
   logic        frame_err;
   logic [7:0]  err_count;

   int n_chk  = 0;
   int n_pass = 0;

   int          hs_cnt = 0;
   int          err_pulses = 0;
   logic [7:0]  hs_addr = '0;
   logic [15:0] hs_data = '0;

   always #5 clk = ~clk;

   uart_cmd_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .rx_done_signal   (rx_done_signal),
      .rx_data          (rx_data),
      .rx_enable_signal (rx_enable_signal),
      .cfg_valid        (cfg_valid),
      .cfg_ready        (cfg_ready),
      .cfg_addr         (cfg_addr),
      .cfg_data         (cfg_data),
      .frame_err        (frame_err),
      .err_count        (err_count)
   );

   // Handshake / error-pulse monitor, sampled mid-low-phase once inputs settle.
   always @(negedge clk) begin
      #2;
      if (!rst) begin
         if (cfg_valid && cfg_ready) begin
            hs_cnt  = hs_cnt + 1;
            hs_addr = cfg_addr;
            hs_data = cfg_data;
         end
         if (frame_err) err_pulses = err_pulses + 1;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_done_signal = 1'b1;
      rx_data        = b;
      @(negedge clk);
      rx_done_signal = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                             input logic [7:0] l, input logic [7:0] s);
      send_byte(8'hAA);
      send_byte(a);
      send_byte(h);
      send_byte(l);
      send_byte(s);
   endtask

   task automatic test_reset;
      rst = 1'b1; rx_done_signal = 1'b0; rx_data = '0; cfg_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++; if (rx_enable_signal !== 1'b0) $display("FAIL rst_rx_en: got %b want 0", rx_enable_signal); else n_pass++;
      n_chk++; if (cfg_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", cfg_valid); else n_pass++;
      n_chk++; if (cfg_addr !== 8'h00 || cfg_data !== 16'h0000) $display("FAIL rst_cfg: got %h/%h want 00/0000", cfg_addr, cfg_data); else n_pass++;
      n_chk++; if (frame_err !== 1'b0 || err_count !== 8'h00) $display("FAIL rst_err: got %b/%h want 0/00", frame_err, err_count); else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_chk++; if (rx_enable_signal !== 1'b1) $display("FAIL rst_release_rx_en: got %b want 1", rx_enable_signal); else n_pass++;
   endtask

   task automatic test_good_frame;
      int hs0, e0;
      hs0 = hs_cnt; e0 = err_pulses;
      cfg_ready = 1'b1;
      send_frame(8'h12, 8'h34, 8'h56, 8'h9C);
      n_chk++; if (cfg_valid !== 1'b1) $display("FAIL good_valid: got %b want 1", cfg_valid); else n_pass++;
      n_chk++; if (cfg_addr !== 8'h12 || cfg_data !== 16'h3456) $display("FAIL good_cfg: got %h/%h want 12/3456", cfg_addr, cfg_data); else n_pass++;
      @(negedge clk);
      n_chk++; if (cfg_valid !== 1'b0 || rx_enable_signal !== 1'b1) $display("FAIL good_after: got valid %b rx_en %b want 0 1", cfg_valid, rx_enable_signal); else n_pass++;
      repeat (2) @(negedge clk);
      n_chk++; if (hs_cnt - hs0 !== 1) $display("FAIL good_hs_count: got %0d want 1", hs_cnt - hs0); else n_pass++;
      n_chk++; if (err_pulses - e0 !== 0) $display("FAIL good_no_err: got %0d want 0", err_pulses - e0); else n_pass++;
   endtask

   task automatic test_bad_checksum;
      int hs0, e0;
      hs0 = hs_cnt; e0 = err_pulses;
      send_frame(8'h12, 8'h34, 8'h56, 8'h9D);
      n_chk++; if (cfg_valid !== 1'b0) $display("FAIL bad_valid: got %b want 0", cfg_valid); else n_pass++;
      n_chk++; if (frame_err !== 1'b1) $display("FAIL bad_err_pulse: got %b want 1", frame_err); else n_pass++;
      @(negedge clk);
      n_chk++; if (frame_err !== 1'b0) $display("FAIL bad_err_one_cycle: got %b want 0", frame_err); else n_pass++;
      n_chk++; if (err_count !== 8'h01) $display("FAIL bad_err_count: got %h want 01", err_count); else n_pass++;
      repeat (2) @(negedge clk);
      n_chk++; if (hs_cnt !== hs0 || err_pulses - e0 !== 1) $display("FAIL bad_counts: got hs %0d err %0d want 0 1", hs_cnt - hs0, err_pulses - e0); else n_pass++;
      send_frame(8'h21, 8'h10, 8'h01, 8'h32);
      n_chk++; if (cfg_valid !== 1'b1 || cfg_addr !== 8'h21 || cfg_data !== 16'h1001) $display("FAIL bad_then_good: got %b %h %h want 1 21 1001", cfg_valid, cfg_addr, cfg_data); else n_pass++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_pressure;
      int hs0;
      logic bad;
      hs0 = hs_cnt; bad = 1'b0;
      cfg_ready = 1'b0;
      send_frame(8'h12, 8'h34, 8'h56, 8'h9C);
      for (int i = 0; i < 50; i++) begin
         if (!(cfg_valid === 1'b1 && rx_enable_signal === 1'b0 &&
               cfg_addr === 8'h12 && cfg_data === 16'h3456)) bad = 1'b1;
         rx_done_signal = (i == 20);
         rx_data        = (i == 20) ? 8'hAA : 8'h00;
         @(negedge clk);
      end
      rx_done_signal = 1'b0;
      n_chk++; if (bad !== 1'b0) $display("FAIL bp_hold: got unstable %b want 0", bad); else n_pass++;
      n_chk++; if (hs_cnt !== hs0) $display("FAIL bp_no_hs: got %0d want 0", hs_cnt - hs0); else n_pass++;
      cfg_ready = 1'b1;
      @(negedge clk);
      n_chk++; if (cfg_valid !== 1'b0 || rx_enable_signal !== 1'b1) $display("FAIL bp_release: got valid %b rx_en %b want 0 1", cfg_valid, rx_enable_signal); else n_pass++;
      repeat (2) @(negedge clk);
      n_chk++; if (hs_cnt - hs0 !== 1 || hs_addr !== 8'h12 || hs_data !== 16'h3456) $display("FAIL bp_hs: got %0d %h %h want 1 12 3456", hs_cnt - hs0, hs_addr, hs_data); else n_pass++;
   endtask

   task automatic test_garbage;
      int hs0, e0;
      logic [7:0] seq [7];
      hs0 = hs_cnt; e0 = err_pulses;
      seq = '{8'h00, 8'hFF, 8'hAA, 8'h01, 8'h00, 8'h02, 8'h03};
      foreach (seq[i]) send_byte(seq[i]);
      n_chk++; if (cfg_valid !== 1'b1 || cfg_addr !== 8'h01 || cfg_data !== 16'h0002) $display("FAIL garbage_cfg: got %b %h %h want 1 01 0002", cfg_valid, cfg_addr, cfg_data); else n_pass++;
      repeat (3) @(negedge clk);
      n_chk++; if (err_pulses !== e0 || hs_cnt - hs0 !== 1) $display("FAIL garbage_counts: got err %0d hs %0d want 0 1", err_pulses - e0, hs_cnt - hs0); else n_pass++;
   endtask

   task automatic test_err_saturate;
      int e0;
      e0 = err_pulses;
      for (int i = 0; i < 260; i++) send_frame(8'h00, 8'h00, 8'h00, 8'h01);
      repeat (3) @(negedge clk);
      n_chk++; if (err_count !== 8'hFF) $display("FAIL sat_count: got %h want ff", err_count); else n_pass++;
      n_chk++; if (err_pulses - e0 !== 260) $display("FAIL sat_pulses: got %0d want 260", err_pulses - e0); else n_pass++;
   endtask

   task automatic test_reset_mid_frame;
      int hs0;
      hs0 = hs_cnt;
      send_byte(8'hAA);
      send_byte(8'h12);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++; if (err_count !== 8'h00 || rx_enable_signal !== 1'b0) $display("FAIL midrst_in_reset: got %h %b want 00 0", err_count, rx_enable_signal); else n_pass++;
      rst = 1'b0;
      send_byte(8'h34);
      send_byte(8'h56);
      send_byte(8'h9C);
      n_chk++; if (cfg_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", cfg_valid); else n_pass++;
      repeat (3) @(negedge clk);
      n_chk++; if (hs_cnt !== hs0 || err_count !== 8'h00) $display("FAIL midrst_after: got hs %0d err %h want 0 00", hs_cnt - hs0, err_count); else n_pass++;
   endtask

`ifdef UART_CMD_TIMEOUT_EN
   task automatic test_timeout;
      int hs0;
      send_byte(8'hAA);
      send_byte(8'h12);
      repeat (2399) @(negedge clk);
      n_chk++; if (frame_err !== 1'b0 || err_count !== 8'h00) $display("FAIL tmo_early: got %b %h want 0 00", frame_err, err_count); else n_pass++;
      @(negedge clk);
      n_chk++; if (frame_err !== 1'b1 || err_count !== 8'h01) $display("FAIL tmo_fire: got %b %h want 1 01", frame_err, err_count); else n_pass++;
      @(negedge clk);
      n_chk++; if (frame_err !== 1'b0) $display("FAIL tmo_one_cycle: got %b want 0", frame_err); else n_pass++;
      send_frame(8'h05, 8'h00, 8'h07, 8'h0C);
      n_chk++; if (cfg_valid !== 1'b1 || cfg_addr !== 8'h05 || cfg_data !== 16'h0007) $display("FAIL tmo_back_idle: got %b %h %h want 1 05 0007", cfg_valid, cfg_addr, cfg_data); else n_pass++;
      repeat (2) @(negedge clk);
      hs0 = hs_cnt;
      send_byte(8'hAA);
      send_byte(8'h12);
      repeat (2398) @(negedge clk);
      send_byte(8'h34);
      send_byte(8'h56);
      send_byte(8'h9C);
      n_chk++; if (cfg_valid !== 1'b1 || cfg_data !== 16'h3456 || err_count !== 8'h01) $display("FAIL tmo_byte_wins: got %b %h %h want 1 3456 01", cfg_valid, cfg_data, err_count); else n_pass++;
      repeat (2) @(negedge clk);
      n_chk++; if (hs_cnt - hs0 !== 1) $display("FAIL tmo_byte_wins_hs: got %0d want 1", hs_cnt - hs0); else n_pass++;
   endtask
`else
   task automatic test_no_timeout;
      send_byte(8'hAA);
      send_byte(8'h12);
      repeat (3000) @(negedge clk);
      n_chk++; if (frame_err !== 1'b0 || err_count !== 8'h00) $display("FAIL wait_no_err: got %b %h want 0 00", frame_err, err_count); else n_pass++;
      send_byte(8'h34);
      send_byte(8'h56);
      send_byte(8'h9C);
      n_chk++; if (cfg_valid !== 1'b1 || cfg_addr !== 8'h12 || cfg_data !== 16'h3456) $display("FAIL wait_frame: got %b %h %h want 1 12 3456", cfg_valid, cfg_addr, cfg_data); else n_pass++;
      repeat (2) @(negedge clk);
   endtask
`endif

   initial begin
      test_reset;
      test_good_frame;
      test_bad_checksum;
      test_back_pressure;
      test_garbage;
      test_err_saturate;
      test_reset_mid_frame;
`ifdef UART_CMD_TIMEOUT_EN
      test_timeout;
`else
      test_no_timeout;
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command-frame controller sitting directly behind rx_uart.
- Drives rx_enable_signal and consumes rx_done_signal/rx_data.
- Assembles fixed 5-byte frames: header, addr, data_hi, data_lo, checksum.
- Emits validated register-write commands on a valid/ready config port feeding the video-path register bank.
- Provides back-pressure by withdrawing rx_enable_signal.

Parameters:
- HEADER, 8'hAA, frame start byte.
- TIMEOUT_CYCLES, 2400, max clk cycles between bytes inside a frame (12 bit-times at 200 clk/bit).
- CNT_W, 12, width of the inter-byte timer; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_done_signal  in  1  one-cycle pulse from rx_uart; rx_data is valid in the same cycle.
- rx_data  in  8  received byte.
- rx_enable_signal  out  1  enable to rx_uart.
- cfg_valid  out  1  command available.
- cfg_ready  in  1  consumer accepts the command.
- cfg_addr  out  8  register address.
- cfg_data  out  16  register data, {data_hi, data_lo}.
- frame_err  out  1  one-cycle pulse on checksum failure or timeout.
- err_count  out  8  saturating count of frame_err pulses.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, rx_enable_signal=0, cfg_valid=0, cfg_addr=0, cfg_data=0, frame_err=0, err_count=0, timer=0.
- rx_enable_signal is registered: 1 in IDLE, ADDR, DHI, DLO and SUM; 0 in ISSUE. It goes to 1 on the first clk edge after reset release.
- A byte is "taken" only when rx_done_signal=1 and the current state is a collecting state. Pulses in ISSUE are ignored.
- State transitions:
  - IDLE: taken byte == HEADER -> ADDR. Any other byte is discarded silently (no error).
  - ADDR: latch the byte into addr_r; sum_r = byte; -> DHI.
  - DHI: latch hi_r; sum_r += byte (mod 256); -> DLO.
  - DLO: latch lo_r; sum_r += byte; -> SUM.
  - SUM: if byte == sum_r -> ISSUE, load cfg_addr/cfg_data and set cfg_valid=1 on the same edge. If the byte mismatches -> IDLE, pulse frame_err, increment err_count.
  - ISSUE: hold cfg_valid, cfg_addr and cfg_data stable until cfg_valid && cfg_ready. On that edge cfg_valid=0 -> IDLE.
- Latency: cfg_valid rises on the clk edge that samples the checksum byte's rx_done_signal, i.e. 1 cycle after the pulse.
- A HEADER value appearing as payload is treated as data; there is no resync mid-frame.
- err_count saturates at 8'hFF and does not wrap.
- Reset mid-frame or mid-ISSUE aborts immediately: partial bytes are lost and err_count is cleared.

Optional Feature:
- Macro: UART_CMD_TIMEOUT_EN.
- When defined:
  - timer clears on every taken byte and in IDLE/ISSUE.
  - timer increments each cycle in ADDR, DHI, DLO and SUM.
  - When timer reaches TIMEOUT_CYCLES-1 -> IDLE, pulse frame_err, increment err_count.
  - If a taken byte and the timeout occur in the same cycle, the byte wins: normal transition, no error.
- When not defined: no timer logic; a partial frame waits indefinitely.

Decomposition:
- Package uart_cmd_pkg holds:
  - state enum: IDLE, ADDR, DHI, DLO, SUM, ISSUE;
  - default HEADER;
  - FRAME_LEN=5.
- Sub-module uart_cmd_timeout, the inter-byte timer, is instantiated only under UART_CMD_TIMEOUT_EN. The rest stays flat.

Test Plan:
- Good frame: AA 12 34 56 9C, cfg_ready=1 -> one cfg_valid pulse with cfg_addr=8'h12, cfg_data=16'h3456; frame_err stays 0.
- Bad checksum: AA 12 34 56 9D -> no cfg_valid; frame_err pulses once; err_count=1. A following good frame is then accepted.
- Back-pressure: good frame with cfg_ready=0 for 50 cycles -> cfg_valid held and rx_enable_signal=0 throughout; a byte pulsed meanwhile is ignored. cfg_ready=1 -> handshake completes, rx_enable_signal returns to 1.
- Garbage then frame: 00 FF AA 01 00 02 03 -> no errors; cfg_addr=8'h01, cfg_data=16'h0002.
- Reset mid-frame: AA 12, then rst asserted for 3 cycles, then 34 56 9C -> no cfg_valid; err_count=0.
- UART_CMD_TIMEOUT_EN: AA 12, then 2400 idle cycles -> frame_err pulses and the controller returns to IDLE. A byte arriving exactly on cycle 2399 is taken instead, with no error.
